// File: rtl/paddle_if.sv
// paddle_if: button/status inputs and striker/tick outputs of one paddle controller
interface paddle_if;
    logic       btn_up, btn_down, btn_left, btn_right, goal, halt;
    logic [9:0] pos_x, pos_y;
    logic       cursor_clk, prev_cursor_clk, frozen;
    modport master(output btn_up, btn_down, btn_left, btn_right, goal, halt,
                   input pos_x, pos_y, cursor_clk, prev_cursor_clk, frozen);
    modport slave(input btn_up, btn_down, btn_left, btn_right, goal, halt,
                  output pos_x, pos_y, cursor_clk, prev_cursor_clk, frozen);
endinterface

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced push-button striker with cursor tick, goal freeze and halt hold
module paddle_ctrl #(
    parameter int TICK_DIV     = 500000,
    parameter int STEP         = 4,
    parameter int X_MIN        = 234,
    parameter int X_MAX        = 464,
    parameter int Y_MIN        = 111,
    parameter int Y_MAX        = 431,
    parameter int X_INIT       = 280,
    parameter int Y_INIT       = 271,
    parameter int DEBOUNCE     = 3,
    parameter int FREEZE_TICKS = 50
) (
    input logic clk,
    input logic clr,
    paddle_if.slave p
);
    localparam int DW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE + 1);
    localparam int FW = $clog2(FREEZE_TICKS + 1);
    localparam logic signed [10:0] SS = 11'(STEP);
    localparam logic signed [10:0] XL = 11'(X_MIN);
    localparam logic signed [10:0] XH = 11'(X_MAX);
    localparam logic signed [10:0] YL = 11'(Y_MIN);
    localparam logic signed [10:0] YH = 11'(Y_MAX);
    typedef enum logic [1:0] {PLAY, FREEZE, HOLD} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [3:0] s1, s2, pr;
    logic [BW-1:0] bc [4];
    logic [BW-1:0] bn [4];
    logic [FW-1:0] fc;
    logic goal_d, pend, step;
    logic signed [10:0] dx, dy, sx, sy;
    logic [9:0] mx, my;
    assign step = p.cursor_clk & ~p.prev_cursor_clk;
    // button bits: 3 up, 2 down, 1 left, 0 right; pressed looks at the post-step count
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bn[i] = !s2[i] ? '0 : (bc[i] == BW'(DEBOUNCE)) ? bc[i] : bc[i] + 1'b1;
            pr[i] = bn[i] == BW'(DEBOUNCE);
        end
        dx = (pr[0] && !pr[1]) ? SS : (pr[1] && !pr[0]) ? -SS : '0;
        dy = (pr[2] && !pr[3]) ? SS : (pr[3] && !pr[2]) ? -SS : '0;
        sx = $signed({1'b0, p.pos_x}) + dx;
        sy = $signed({1'b0, p.pos_y}) + dy;
        mx = (sx < XL) ? 10'(X_MIN) : (sx > XH) ? 10'(X_MAX) : sx[9:0];
        my = (sy < YL) ? 10'(Y_MIN) : (sy > YH) ? 10'(Y_MAX) : sy[9:0];
    end
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            div               <= '0;
            p.cursor_clk      <= 1'b0;
            p.prev_cursor_clk <= 1'b0;
            s1                <= '0;
            s2                <= '0;
            goal_d            <= 1'b0;
            pend              <= 1'b0;
        end else begin
            div               <= (div == DW'(TICK_DIV - 1)) ? '0 : div + 1'b1;
            p.cursor_clk      <= (div == DW'(TICK_DIV - 1)) ? ~p.cursor_clk : p.cursor_clk;
            p.prev_cursor_clk <= p.cursor_clk;
            s1                <= {p.btn_up, p.btn_down, p.btn_left, p.btn_right};
            s2                <= s1;
            goal_d            <= p.goal;
            pend              <= (p.goal & ~goal_d) | (pend & ~step);
        end
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            state    <= PLAY;
            bc       <= '{default: '0};
            fc       <= '0;
            p.pos_x  <= 10'(X_INIT);
            p.pos_y  <= 10'(Y_INIT);
            p.frozen <= 1'b0;
        end else if (step) begin
            bc <= bn;
            case (state)
                PLAY:
                    if (pend) begin
                        p.pos_x  <= 10'(X_INIT);
                        p.pos_y  <= 10'(Y_INIT);
                        fc       <= '0;
                        state    <= FREEZE;
                        p.frozen <= 1'b1;
                    end else if (p.halt) begin
                        state    <= HOLD;
                        p.frozen <= 1'b1;
                    end else begin
                        p.pos_x <= mx;
                        p.pos_y <= my;
                    end
                FREEZE:
                    if (pend) begin
                        p.pos_x <= 10'(X_INIT);
                        p.pos_y <= 10'(Y_INIT);
                        fc      <= '0;
                    end else if (fc == FW'(FREEZE_TICKS - 1)) begin
                        state    <= p.halt ? HOLD : PLAY;
                        p.frozen <= p.halt;
                    end else begin
                        fc <= fc + 1'b1;
                    end
                HOLD:
                    if (pend) begin
                        p.pos_x <= 10'(X_INIT);
                        p.pos_y <= 10'(Y_INIT);
                        fc      <= '0;
                        state   <= FREEZE;
                    end else if (!p.halt) begin
                        state    <= PLAY;
                        p.frozen <= 1'b0;
                    end
                default: begin
                    state    <= PLAY;
                    p.frozen <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed stimulus with a per-step expectation queue checked by a monitor
module tb_paddle_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b0;
    paddle_if b();
    paddle_ctrl #(.TICK_DIV(2), .STEP(4), .DEBOUNCE(2), .FREEZE_TICKS(3), .X_INIT(280), .Y_INIT(271))
        dut (.clk(clk), .clr(clr), .p(b));
    always #5 clk = ~clk;
    typedef struct {int x; int y; int f;} exp_t;
    exp_t q[$];
    int checks = 0;
    int fails = 0;
    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask
    // queue the state expected after the next step, then wait until the monitor consumed it
    task automatic ex(input int x, input int y, input int f);
        q.push_back('{x, y, f});
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("step_timeout_pending", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask
    task automatic pulse_goal();
        b.goal = 1'b1;
        @(negedge clk);
        b.goal = 1'b0;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b.cursor_clk && !b.prev_cursor_clk) begin
                @(negedge clk);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("step_pos_x", int'(b.pos_x), e.x);
                    chk("step_pos_y", int'(b.pos_y), e.y);
                    chk("step_frozen", int'(b.frozen), e.f);
                end
            end
        end
    end
    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
    initial begin
        {b.btn_up, b.btn_down, b.btn_left, b.btn_right, b.goal, b.halt} = '0;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        chk("rst_pos_x", int'(b.pos_x), 280);
        chk("rst_pos_y", int'(b.pos_y), 271);
        chk("rst_frozen", int'(b.frozen), 0);
        chk("rst_cursor", int'(b.cursor_clk), 0);
        chk("rst_prev", int'(b.prev_cursor_clk), 0);
        @(negedge clk) chk("tick1_cursor", int'(b.cursor_clk), 0);
        @(negedge clk) chk("tick2_cursor", int'(b.cursor_clk), 1);
        chk("tick2_prev", int'(b.prev_cursor_clk), 0);
        @(negedge clk) chk("tick3_cursor", int'(b.cursor_clk), 1);
        chk("tick3_prev", int'(b.prev_cursor_clk), 1);
        @(negedge clk) chk("tick4_cursor", int'(b.cursor_clk), 0);
        chk("tick4_prev", int'(b.prev_cursor_clk), 1);
        b.btn_right = 1'b1;
        ex(280, 271, 0);
        for (int x = 284; x <= 464; x += 4) ex(x, 271, 0);
        repeat (2) ex(464, 271, 0);
        b.btn_left = 1'b1;
        repeat (3) ex(464, 271, 0);
        b.btn_right = 1'b0;
        for (int x = 460; x >= 236; x -= 4) ex(x, 271, 0);
        repeat (2) ex(234, 271, 0);
        b.btn_left = 1'b0;
        b.btn_up = 1'b1;
        ex(234, 271, 0);
        for (int y = 267; y >= 111; y -= 4) ex(234, y, 0);
        repeat (2) ex(234, 111, 0);
        b.btn_up = 1'b0;
        b.btn_right = 1'b1;
        b.btn_down = 1'b1;
        ex(234, 111, 0);
        ex(238, 115, 0);
        ex(242, 119, 0);
        ex(246, 123, 0);
        b.btn_down = 1'b0;
        ex(250, 123, 0);
        pulse_goal();
        repeat (3) ex(280, 271, 1);
        ex(280, 271, 0);
        ex(284, 271, 0);
        b.halt = 1'b1;
        repeat (2) ex(284, 271, 1);
        pulse_goal();
        repeat (5) ex(280, 271, 1);
        b.halt = 1'b0;
        ex(280, 271, 0);
        ex(284, 271, 0);
        pulse_goal();
        repeat (2) ex(280, 271, 1);
        clr = 1'b1;
        #1;
        chk("clr_pos_x", int'(b.pos_x), 280);
        chk("clr_pos_y", int'(b.pos_y), 271);
        chk("clr_frozen", int'(b.frozen), 0);
        chk("clr_cursor", int'(b.cursor_clk), 0);
        chk("clr_prev", int'(b.prev_cursor_clk), 0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk) chk("re_tick1_cursor", int'(b.cursor_clk), 0);
        @(negedge clk) chk("re_tick2_cursor", int'(b.cursor_clk), 1);
        chk("re_tick2_prev", int'(b.prev_cursor_clk), 0);
        ex(280, 271, 0);
        ex(284, 271, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Drives one player's striker position (ball_x/ball_y) into the puck mover from four push-buttons.
- Generates the cursor tick pair (cursor_clk, prev_cursor_clk) that the mover edge-detects, so paddle and puck updates land on the same clk cycle.
- Snaps the striker home and freezes it after a goal; holds it while the game is halted.
- Top level instantiates one per player and uses player 1's tick outputs; all instances are reset-aligned, so their ticks are identical.

Parameters:
- TICK_DIV, 500000: clk cycles per cursor_clk half-period; tick period is 2*TICK_DIV.
- STEP, 4: pixels moved per tick.
- X_MIN, 234: left clamp, inclusive.
- X_MAX, 464: right clamp, inclusive. Player 2 uses X_MIN=464, X_MAX=694.
- Y_MIN, 111: top clamp, inclusive.
- Y_MAX, 431: bottom clamp, inclusive.
- X_INIT, 280: home x.
- Y_INIT, 271: home y.
- DEBOUNCE, 3: consecutive tick samples high before a button counts as pressed.
- FREEZE_TICKS, 50: ticks the striker stays frozen after a goal.

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- btn_up  in  1  asynchronous push-button, move -y
- btn_down  in  1  asynchronous push-button, move +y
- btn_left  in  1  asynchronous push-button, move -x
- btn_right  in  1  asynchronous push-button, move +x
- goal  in  1  collide1|collide2 from the mover, level
- halt  in  1  hold striker at its current position
- pos_x  out  10  striker x, to the mover's ball_x
- pos_y  out  10  striker y, to the mover's ball_y
- cursor_clk  out  1  divided tick, registered
- prev_cursor_clk  out  1  cursor_clk delayed one clk
- frozen  out  1  high when state is not PLAY

Behaviour:
- Reset (clr high, asynchronous):
  - pos_x=X_INIT, pos_y=Y_INIT.
  - cursor_clk=0, prev_cursor_clk=0, frozen=0.
  - state=PLAY; divider, debounce and freeze counters cleared.
- Divider:
  - Counter runs 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and cursor_clk toggles.
  - prev_cursor_clk <= cursor_clk every clk.
- step strobe: internal signal = (cursor_clk==1 && prev_cursor_clk==0), one clk wide. This is the same cycle the mover acts on.
- Buttons:
  - Each button passes through a 2-flop synchronizer.
  - On each step, a per-button counter increments (saturating at DEBOUNCE) if the synced level is 1, and clears if it is 0.
  - A button is pressed when its counter == DEBOUNCE.
- Goal:
  - goal_d is registered every clk.
  - goal_rise = goal & ~goal_d, detected on any clk.
  - goal_rise sets a sticky pend flag; pend is consumed on the next step.
- State machine (advances only on step):
  - PLAY:
    - If pend: pos=(X_INIT,Y_INIT), freeze_cnt=0, go to FREEZE.
    - Else if halt: go to HOLD, position unchanged.
    - Else: move.
  - FREEZE:
    - Position held; buttons ignored; freeze_cnt increments each step.
    - If pend: pos snaps home again and freeze_cnt=0 (the freeze restarts).
    - When freeze_cnt reaches FREEZE_TICKS-1: go to HOLD if halt, else PLAY.
  - HOLD:
    - Position held.
    - If pend: snap home and go to FREEZE.
    - Else if !halt: go to PLAY.
  - Priority: goal > halt > movement.
- Move (PLAY only):
  - dx = +STEP if right pressed, -STEP if left pressed, 0 if neither or both.
  - dy = +STEP if down pressed, -STEP if up pressed, 0 if neither or both.
  - Arithmetic is 11-bit signed; the result saturates to [X_MIN,X_MAX] and [Y_MIN,Y_MAX]. No wrap-around at 0 or 1023.
  - Diagonal moves are allowed.
- Outputs:
  - pos_x/pos_y are registered and change only on step cycles (or on clr).
  - frozen is registered and updates with the state.
- Debounce counters keep running in every state, so a button held through FREEZE moves the striker on the first PLAY step.
- clr mid-FREEZE or mid-HOLD: immediate return to the reset values.

Test Plan:
Bench parameters: TICK_DIV=2, STEP=4, DEBOUNCE=2, FREEZE_TICKS=3, X_INIT=280, Y_INIT=271.
1. Reset: clr high then low -> pos=(280,271), frozen=0; cursor_clk rises on the 2nd clk after release, period 4 clk; prev_cursor_clk lags cursor_clk by exactly 1 clk.
2. Hold btn_right -> no move on the first step; then pos_x = 284, 288, 292 on successive steps; pos_y stays 271.
3. X_INIT=460, hold btn_right 5 ticks -> pos_x 464 and stays 464. Press left+right together -> no change. Hold btn_up from y=113 -> pos_y=111 and held.
4. Move to (300,271), pulse goal for 1 clk between steps -> next step pos=(280,271), frozen=1 for 3 steps with btn_right held, then frozen=0 and pos_x=284 on the following step.
5. halt=1 in PLAY -> pos constant, frozen=1. goal pulse while halted -> home, FREEZE 3 steps, then HOLD. halt=0 -> PLAY.
6. Assert clr 1 clk mid-FREEZE -> same clk: pos=(280,271), frozen=0, cursor_clk=0; counters restart.
